// File: rtl/dvp_pixel_tx.sv
// dvp_pixel_tx: OV7670-style DVP source (vsync/href/D), RGB444 stream in, two bytes per pixel.
// Ports: i_pclk, i_rst (async, active high), i_enable, i_pix_data/i_pix_valid/o_pix_ready stream,
//        o_vsync/o_href/o_D video bus, o_underrun and o_frame_done single-cycle pulses.
module dvp_pixel_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        i_pclk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic [11:0] i_pix_data,
  input  logic        i_pix_valid,
  output logic        o_pix_ready,
  output logic        o_vsync,
  output logic        o_href,
  output logic [7:0]  o_D,
  output logic        o_underrun,
  output logic        o_frame_done
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int HREF_LEN = 2 * H_ACTIVE;
  localparam int HW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int V_M1 = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int V_M2 = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int V_MAX = (V_M1 > V_M2) ? V_M1 : V_M2;
  localparam int VW = (V_MAX > 1) ? $clog2(V_MAX) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(LINE_LEN - 1);
  localparam logic [HW:0] H_HREF = (HW + 1)'(HREF_LEN);

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    VFRONT
  } state_t;

  state_t        state;
  state_t        nxt_state;
  logic [HW-1:0] h_cnt;
  logic [HW-1:0] nxt_h;
  logic [VW-1:0] v_cnt;
  logic [VW-1:0] nxt_v;
  logic [7:0]    pix_gb;
  logic          nxt_href;
  logic          nxt_first;
  logic          nxt_done;

  function automatic logic [VW-1:0] sec_last(input state_t s);
    logic [VW-1:0] r;
    r = '0;
    unique case (s)
      VSYNC:   r = VW'(VSYNC_LINES - 1);
      VBACK:   r = VW'(V_BACK - 1);
      ACTIVE:  r = VW'(V_ACTIVE - 1);
      VFRONT:  r = VW'(V_FRONT - 1);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Next non-empty section after s; IDLE in means frame start,
  // IDLE out means the frame has ended.
  function automatic state_t next_sec(input state_t s);
    state_t r;
    r = IDLE;
    if (s == IDLE && VSYNC_LINES > 0)
      r = VSYNC;
    else if ((s == IDLE || s == VSYNC) && V_BACK > 0)
      r = VBACK;
    else if (s != ACTIVE && s != VFRONT && V_ACTIVE > 0)
      r = ACTIVE;
    else if (s != VFRONT && V_FRONT > 0)
      r = VFRONT;
    return r;
  endfunction

  // Position of the cycle launched by the next edge.
  always_comb begin
    nxt_state = state;
    nxt_h     = h_cnt;
    nxt_v     = v_cnt;
    if (state == IDLE) begin
      if (i_enable)
        nxt_state = next_sec(IDLE);
    end else if (h_cnt != H_LAST) begin
      nxt_h = h_cnt + 1'b1;
    end else begin
      nxt_h = '0;
      if (v_cnt != sec_last(state)) begin
        nxt_v = v_cnt + 1'b1;
      end else begin
        nxt_v     = '0;
        nxt_state = next_sec(state);
        if (nxt_state == IDLE && i_enable)
          nxt_state = next_sec(IDLE);
      end
    end
  end

  assign nxt_href  = (nxt_state == ACTIVE) &&
                     ({1'b0, nxt_h} < H_HREF);
  assign nxt_first = nxt_href && !nxt_h[0];
  assign nxt_done  = (nxt_state != IDLE) &&
                     (nxt_h == H_LAST) &&
                     (nxt_v == sec_last(nxt_state)) &&
                     (next_sec(nxt_state) == IDLE);

  assign o_pix_ready = nxt_first && !i_rst;

  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      h_cnt        <= '0;
      v_cnt        <= '0;
      pix_gb       <= '0;
      o_vsync      <= 1'b0;
      o_href       <= 1'b0;
      o_D          <= 8'h00;
      o_underrun   <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      state        <= nxt_state;
      h_cnt        <= nxt_h;
      v_cnt        <= nxt_v;
      o_vsync      <= (nxt_state == VSYNC);
      o_href       <= nxt_href;
      o_frame_done <= nxt_done;
      o_underrun   <= 1'b0;
      if (nxt_first) begin
        if (i_pix_valid) begin
          pix_gb <= i_pix_data[7:0];
          o_D    <= {4'h0, i_pix_data[11:8]};
        end else begin
          // Missing pixel goes out as black.
          pix_gb     <= 8'h00;
          o_D        <= 8'h00;
          o_underrun <= 1'b1;
        end
      end else if (nxt_href) begin
        o_D <= pix_gb;
      end else begin
        o_D <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_dvp_pixel_tx.sv
// tb_dvp_pixel_tx: self-checking bench for dvp_pixel_tx with small frame geometry.
// Reference timing is computed from frame offset arithmetic.
module tb_dvp_pixel_tx;

  localparam int HA = 4;
  localparam int HB = 3;
  localparam int VA = 2;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int VF = 1;
  localparam int LL = 2 * HA + HB;
  localparam int FL = (VS + VB + VA + VF) * LL;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] pd;
  logic        pv;
  logic        ready;
  logic        vs;
  logic        hr;
  logic [7:0]  d;
  logic        und;
  logic        fd;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] s_vec [4] = '{12'hABC, 12'h123, 12'hF0F, 12'h456};
  logic [7:0]  s_exp [11] = '{8'h0A, 8'hBC, 8'h01, 8'h23,
                              8'h0F, 8'h0F, 8'h04, 8'h56,
                              8'h00, 8'h00, 8'h00};
  logic        u_val [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [11:0] u_dat [4] = '{12'hABC, 12'h123, 12'h123, 12'hF0F};
  logic [7:0]  u_exp [8] = '{8'h0A, 8'hBC, 8'h00, 8'h00,
                             8'h01, 8'h23, 8'h0F, 8'h0F};

  dvp_pixel_tx #(
    .H_ACTIVE   (HA),
    .H_BLANK    (HB),
    .V_ACTIVE   (VA),
    .VSYNC_LINES(VS),
    .V_BACK     (VB),
    .V_FRONT    (VF)
  ) dut (
    .i_pclk      (clk),
    .i_rst       (rst),
    .i_enable    (en),
    .i_pix_data  (pd),
    .i_pix_valid (pv),
    .o_pix_ready (ready),
    .o_vsync     (vs),
    .o_href      (hr),
    .o_D         (d),
    .o_underrun  (und),
    .o_frame_done(fd)
  );

  always #5 clk = ~clk;

  // Reference: frame offset t counted from the first vsync cycle.
  function automatic logic m_vsync(input int t);
    return (t / LL) < VS;
  endfunction

  function automatic logic m_href(input int t);
    int ln;
    ln = t / LL;
    return (ln >= VS + VB) && (ln < VS + VB + VA) && ((t % LL) < 2 * HA);
  endfunction

  function automatic logic m_first(input int t);
    return m_href(t) && (((t % LL) % 2) == 0);
  endfunction

  function automatic logic m_done(input int t);
    return t == FL - 1;
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    en  = 1'b0;
    pv  = 1'b0;
    pd  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    en  = 1'b0;
    pv  = 1'b0;
    pd  = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({vs, hr, d, und, fd, ready} !== 13'b0) begin
      n_err++;
      $display("FAIL reset_state: got %b want 0",
               {vs, hr, d, und, fd, ready});
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      pv = 1'($urandom);
      pd = 12'($urandom);
      @(negedge clk);
      n_cmp++;
      if ({vs, hr, d, und, fd, ready} !== 13'b0) begin
        n_err++;
        $display("FAIL idle_quiet c=%0d: got %b want 0",
                 c, {vs, hr, d, und, fd, ready});
      end
    end
  endtask

  task automatic test_vsync_start;
    logic [9:0] exp;
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      exp = {(k < 11) ? 1'b1 : 1'b0, 1'b0, 8'h00};
      n_cmp++;
      if ({vs, hr, d} !== exp) begin
        n_err++;
        $display("FAIL vsync_start k=%0d: got %b want %b",
                 k, {vs, hr, d}, exp);
      end
    end
  endtask

  task automatic test_stream;
    int k;
    int i;
    do_reset();
    en = 1'b1;
    pv = 1'b1;
    k  = 0;
    for (int t = 0; t < FL; t++) begin
      @(negedge clk);
      if (t >= 2 * LL && t < 4 * LL) begin
        i = (t - 2 * LL) % LL;
        n_cmp++;
        if ({hr, d} !== {(i < 8) ? 1'b1 : 1'b0, s_exp[i]}) begin
          n_err++;
          $display("FAIL stream_bytes t=%0d: got href=%b D=%h want href=%b D=%h",
                   t, hr, d, (i < 8), s_exp[i]);
        end
      end
      n_cmp++;
      if (ready !== m_first((t + 1) % FL)) begin
        n_err++;
        $display("FAIL stream_ready t=%0d: got %b want %b",
                 t, ready, m_first((t + 1) % FL));
      end
      if (m_first((t + 1) % FL)) begin
        pd = s_vec[k % 4];
        k++;
      end
    end
  endtask

  task automatic test_underrun;
    int s;
    logic eu;
    do_reset();
    en = 1'b1;
    pv = 1'b1;
    pd = 12'hABC;
    for (int t = 0; t < 4 * LL; t++) begin
      @(negedge clk);
      if (t >= 2 * LL && t < 2 * LL + 8) begin
        n_cmp++;
        if (d !== u_exp[t - 2 * LL]) begin
          n_err++;
          $display("FAIL underrun_bytes t=%0d: got %h want %h",
                   t, d, u_exp[t - 2 * LL]);
        end
      end
      eu = (t == 2 * LL + 2);
      n_cmp++;
      if (und !== eu) begin
        n_err++;
        $display("FAIL underrun_pulse t=%0d: got %b want %b", t, und, eu);
      end
      if (m_first(t + 1)) begin
        if (t + 1 < 3 * LL) begin
          s  = ((t + 1) % LL) / 2;
          pv = u_val[s];
          pd = u_dat[s];
        end else begin
          pv = 1'b1;
          pd = 12'hABC;
        end
      end
    end
  endtask

  task automatic test_continuous;
    logic [7:0] exp_d;
    logic       exp_u;
    logic [7:0] pend;
    logic [2:0] exp_c;
    logic       prev_h;
    int         bursts;
    int         t;
    int         nt;
    logic [11:0] rd;
    do_reset();
    exp_d  = 8'h00;
    exp_u  = 1'b0;
    pend   = 8'h00;
    prev_h = 1'b0;
    bursts = 0;
    en     = 1'b1;
    for (int c = 0; c < 3 * FL; c++) begin
      @(negedge clk);
      t = c % FL;
      exp_c = {m_vsync(t), m_href(t), m_done(t)};
      n_cmp++;
      if ({vs, hr, fd} !== exp_c) begin
        n_err++;
        $display("FAIL cont_ctrl c=%0d: got vs/href/done=%b want %b",
                 c, {vs, hr, fd}, exp_c);
      end
      n_cmp++;
      if ({d, und} !== {exp_d, exp_u}) begin
        n_err++;
        $display("FAIL cont_data c=%0d: got D=%h und=%b want D=%h und=%b",
                 c, d, und, exp_d, exp_u);
      end
      nt = (t + 1) % FL;
      n_cmp++;
      if (ready !== m_first(nt)) begin
        n_err++;
        $display("FAIL cont_ready c=%0d: got %b want %b",
                 c, ready, m_first(nt));
      end
      if (hr && !prev_h)
        bursts++;
      prev_h = hr;
      if (t == FL - 1) begin
        n_cmp++;
        if (bursts != VA) begin
          n_err++;
          $display("FAIL cont_bursts c=%0d: got %0d want %0d",
                   c, bursts, VA);
        end
        bursts = 0;
      end
      rd = 12'($urandom);
      if (m_first(nt)) begin
        pv = ($urandom_range(0, 3) != 0);
        pd = rd;
        if (pv) begin
          exp_d = {4'h0, rd[11:8]};
          exp_u = 1'b0;
          pend  = rd[7:0];
        end else begin
          exp_d = 8'h00;
          exp_u = 1'b1;
          pend  = 8'h00;
        end
      end else begin
        pv    = 1'($urandom);
        pd    = rd;
        exp_u = 1'b0;
        exp_d = m_href(nt) ? pend : 8'h00;
      end
    end
  endtask

  task automatic test_enable_drop;
    logic [2:0] exp_c;
    int         fd_cnt;
    do_reset();
    en     = 1'b1;
    pv     = 1'b1;
    pd     = 12'($urandom);
    fd_cnt = 0;
    for (int c = 0; c < FL + 20; c++) begin
      @(negedge clk);
      exp_c = (c < FL) ? {m_vsync(c), m_href(c), m_done(c)} : 3'b000;
      n_cmp++;
      if ({vs, hr, fd} !== exp_c) begin
        n_err++;
        $display("FAIL drop_ctrl c=%0d: got %b want %b",
                 c, {vs, hr, fd}, exp_c);
      end
      if (c >= FL) begin
        n_cmp++;
        if ({d, ready} !== 9'b0) begin
          n_err++;
          $display("FAIL drop_idle c=%0d: got D=%h ready=%b want 0",
                   c, d, ready);
        end
      end
      if (fd)
        fd_cnt++;
      if (c == 2 * LL + 2)
        en = 1'b0;
    end
    n_cmp++;
    if (fd_cnt != 1) begin
      n_err++;
      $display("FAIL drop_done_count: got %0d want 1", fd_cnt);
    end
    en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (vs !== 1'b1) begin
      n_err++;
      $display("FAIL reenable_vsync: got %b want 1", vs);
    end
  endtask

  task automatic test_reset_mid_href;
    do_reset();
    en = 1'b1;
    pv = 1'b1;
    pd = 12'hFFF;
    repeat (2 * LL + 4) @(negedge clk);
    n_cmp++;
    if (hr !== 1'b1) begin
      n_err++;
      $display("FAIL midref_href: got %b want 1", hr);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({vs, hr, d, und, fd, ready} !== 13'b0) begin
      n_err++;
      $display("FAIL midref_async: got %b want 0",
               {vs, hr, d, und, fd, ready});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < FL; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({vs, hr, fd} !== {m_vsync(c), m_href(c), m_done(c)}) begin
        n_err++;
        $display("FAIL midref_restart c=%0d: got %b want %b",
                 c, {vs, hr, fd}, {m_vsync(c), m_href(c), m_done(c)});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    pv  = 1'b0;
    pd  = '0;
    test_reset();
    test_vsync_start();
    test_stream();
    test_underrun();
    test_continuous();
    test_enable_drop();
    test_reset_mid_href();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
